vxe_cu_mem_arbiter: RTL and testbench

Shares one VxE memory request/response port among four requesters: the CU fetch unit and up to three vector-unit load/store clients. Client request channels are granted round-robin into a registered one-entry output slice, with a per-client outstanding-transaction limit. Response status is routed back by the client-id field of the transaction Id. Response data is routed through a small ordered route FIFO.

---
 rtl/vxe_cu_mem_arbiter_pkg.sv | 24 ++
 rtl/vxe_cu_mem_arbiter_fifo.sv | 51 +++++
 rtl/vxe_cu_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_vxe_cu_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vxe_cu_mem_arbiter_pkg.sv
// Shared definitions for the CU memory arbiter: client count, field
// positions inside the transaction id and the response status word.
package vxe_cu_mem_arbiter_pkg;

  localparam int N_CL       = 4;
  localparam int CID_W      = 2;
  localparam int RQA_W      = 44;
  localparam int RSS_W      = 9;
  localparam int RSD_W      = 64;

  // Client id sits in txnid[5:4]; txnid occupies rss[8:3].
  localparam int TXN_CID_LO = 4;
  localparam int RSS_TXN_LO = 3;
  localparam int RSS_CID_LO = RSS_TXN_LO + TXN_CID_LO;
  localparam int RSS_RNW    = 2;

  typedef logic [CID_W-1:0] cid_t;

  typedef struct packed {
    logic found;
    cid_t idx;
  } pick_t;

endpackage

// File: rtl/vxe_cu_mem_arbiter_fifo.sv
// Small synchronous FIFO used to remember which client owns each pending
// read-data beat. DEPTH_POW2 must be at least 1.
module vxe_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_POW2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_POW2:0]   wptr;
  logic [DEPTH_POW2:0]   rptr;
  logic                  do_push;
  logic                  do_pop;

  // Occupancy flags from the wrap-bit pointer pair; head is read directly.
  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[DEPTH_POW2] != rptr[DEPTH_POW2]) &&
               (wptr[DEPTH_POW2-1:0] == rptr[DEPTH_POW2-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rptr[DEPTH_POW2-1:0]];
  end

  // Pointer state, cleared on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_POW2-1:0]] <= push_data;
  end

endmodule

// File: rtl/vxe_cu_mem_arbiter.sv
// Four-client arbiter onto one VxE memory port: round-robin request grant
// into a registered output slice with per-client outstanding limits, status
// routed by txnid client id, read data routed through an ordered owner FIFO.
module vxe_cu_mem_arbiter
  import vxe_cu_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTST        = 8,
  parameter int ROUTE_DEPTH_POW2 = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [N_CL-1:0]         i_cl_rqa_wr,
  input  logic [N_CL*RQA_W-1:0]   i_cl_rqa,
  output logic [N_CL-1:0]         o_cl_rqa_rdy,
  output logic [RQA_W-1:0]        o_rqa,
  output logic                    o_rqa_wr,
  input  logic                    i_rqa_rdy,
  input  logic                    i_rss_vld,
  input  logic [RSS_W-1:0]        i_rss,
  output logic                    o_rss_rd,
  input  logic                    i_rsd_vld,
  input  logic [RSD_W-1:0]        i_rsd,
  output logic                    o_rsd_rd,
  output logic [N_CL-1:0]         o_cl_rss_vld,
  output logic [RSS_W-1:0]        o_cl_rss,
  input  logic [N_CL-1:0]         i_cl_rss_rd,
  output logic [N_CL-1:0]         o_cl_rsd_vld,
  output logic [RSD_W-1:0]        o_cl_rsd,
  input  logic [N_CL-1:0]         i_cl_rsd_rd,
  output logic                    o_busy
);

  localparam logic [7:0] MAX_O = MAX_OUTST[7:0];

  logic [RQA_W-1:0] req [N_CL];
  logic [7:0]       outst [N_CL];
  cid_t             rr;
  logic             load;
  logic [N_CL-1:0]  elig;
  pick_t            pick;
  logic [N_CL-1:0]  dec;
  cid_t             cid;
  logic             rss_pop;
  logic             rd_pop;
  logic             owner_ok;
  cid_t             owner;
  logic             any_outst;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  cid_t             fifo_head;

  // First eligible client at or after the round-robin pointer.
  function automatic pick_t rr_pick(input logic [N_CL-1:0] el, input cid_t start);
    pick_t p;
    cid_t  c;
    p = '0;
    for (int k = N_CL - 1; k >= 0; k--) begin
      c = start + cid_t'(k);
      if (el[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  for (genvar g = 0; g < N_CL; g++) begin : g_req
    assign req[g] = i_cl_rqa[g*RQA_W +: RQA_W];
  end

  // Request side: eligibility, grant, and busy summary.
  always_comb begin
    load      = !o_rqa_wr || i_rqa_rdy;
    any_outst = 1'b0;
    for (int c = 0; c < N_CL; c++) begin
      elig[c]   = i_cl_rqa_wr[c] && (outst[c] < MAX_O);
      any_outst = any_outst || (outst[c] != 8'd0);
    end
    pick         = rr_pick(elig, rr);
    o_cl_rqa_rdy = (load && pick.found) ? (N_CL'(1) << pick.idx) : '0;
    o_busy       = o_rqa_wr || any_outst || !fifo_empty;
  end

  // Output slice and round-robin pointer; holds while upstream stalls.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_rqa    <= '0;
      o_rqa_wr <= 1'b0;
      rr       <= '0;
    end else if (load && pick.found) begin
      o_rqa    <= req[pick.idx];
      o_rqa_wr <= 1'b1;
      rr       <= pick.idx + cid_t'(1);
    end else if (o_rqa_wr && i_rqa_rdy) begin
      o_rqa_wr <= 1'b0;
    end
  end

  // Response routing: status by txnid client id, data by route FIFO head
  // or, with an empty FIFO, by the read status popping in the same cycle.
  always_comb begin
    cid          = i_rss[RSS_CID_LO +: CID_W];
    o_cl_rss     = i_rss;
    o_cl_rss_vld = i_rss_vld ? (N_CL'(1) << cid) : '0;
    o_rss_rd     = i_rss_vld && i_cl_rss_rd[cid] && !(i_rss[RSS_RNW] && fifo_full);
    rss_pop      = o_rss_rd;
    rd_pop       = rss_pop && i_rss[RSS_RNW];
    dec          = rss_pop ? (N_CL'(1) << cid) : '0;
    owner        = fifo_empty ? cid : fifo_head;
    owner_ok     = !fifo_empty || rd_pop;
    o_cl_rsd     = i_rsd;
    o_cl_rsd_vld = (i_rsd_vld && owner_ok) ? (N_CL'(1) << owner) : '0;
    o_rsd_rd     = i_rsd_vld && owner_ok && i_cl_rsd_rd[owner];
    fifo_push    = rd_pop && !(fifo_empty && o_rsd_rd);
    fifo_pop     = o_rsd_rd && !fifo_empty;
  end

  // Per-client outstanding counters; simultaneous grant and status pop cancel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < N_CL; c++) outst[c] <= 8'd0;
    end else begin
      for (int c = 0; c < N_CL; c++) begin
        if (o_cl_rqa_rdy[c] && !dec[c])      outst[c] <= outst[c] + 8'd1;
        else if (dec[c] && !o_cl_rqa_rdy[c]) outst[c] <= outst[c] - 8'd1;
      end
    end
  end

  vxe_fifo #(
    .DATA_WIDTH (CID_W),
    .DEPTH_POW2 (ROUTE_DEPTH_POW2)
  ) u_route (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data (cid),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_vxe_cu_mem_arbiter.sv
// Directed bench for vxe_cu_mem_arbiter with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_vxe_cu_mem_arbiter;

  localparam int MAXO = 2;
  localparam int RDP  = 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic [3:0]    i_cl_rqa_wr;
  logic [175:0]  i_cl_rqa;
  logic [3:0]    o_cl_rqa_rdy;
  logic [43:0]   o_rqa;
  logic          o_rqa_wr;
  logic          i_rqa_rdy;
  logic          i_rss_vld;
  logic [8:0]    i_rss;
  logic          o_rss_rd;
  logic          i_rsd_vld;
  logic [63:0]   i_rsd;
  logic          o_rsd_rd;
  logic [3:0]    o_cl_rss_vld;
  logic [8:0]    o_cl_rss;
  logic [3:0]    i_cl_rss_rd;
  logic [3:0]    o_cl_rsd_vld;
  logic [63:0]   o_cl_rsd;
  logic [3:0]    i_cl_rsd_rd;
  logic          o_busy;

  vxe_cu_mem_arbiter #(.MAX_OUTST(MAXO), .ROUTE_DEPTH_POW2(RDP)) dut (
    .clk(clk), .nrst(nrst),
    .i_cl_rqa_wr(i_cl_rqa_wr), .i_cl_rqa(i_cl_rqa), .o_cl_rqa_rdy(o_cl_rqa_rdy),
    .o_rqa(o_rqa), .o_rqa_wr(o_rqa_wr), .i_rqa_rdy(i_rqa_rdy),
    .i_rss_vld(i_rss_vld), .i_rss(i_rss), .o_rss_rd(o_rss_rd),
    .i_rsd_vld(i_rsd_vld), .i_rsd(i_rsd), .o_rsd_rd(o_rsd_rd),
    .o_cl_rss_vld(o_cl_rss_vld), .o_cl_rss(o_cl_rss), .i_cl_rss_rd(i_cl_rss_rd),
    .o_cl_rsd_vld(o_cl_rsd_vld), .o_cl_rsd(o_cl_rsd), .i_cl_rsd_rd(i_cl_rsd_rd),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_outst [4];
  int         m_rr;
  logic       m_wr;
  logic [43:0] m_rqa;
  int         route_q [$];

  // Model expectations for the current cycle
  logic [3:0] e_rqa_rdy;
  int         e_win;
  logic [3:0] e_rss_vld;
  logic       e_rss_rd;
  logic [3:0] e_rsd_vld;
  logic       e_rsd_rd;
  logic       e_busy;

  logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m_outst[c] = 0;
    m_rr  = 0;
    m_wr  = 1'b0;
    m_rqa = '0;
    route_q.delete();
  endtask

  task automatic model_eval();
    int  cid;
    int  owner;
    int  c;
    bit  have;
    e_rqa_rdy = '0;
    e_win     = 0;
    if (!m_wr || i_rqa_rdy) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (i_cl_rqa_wr[c] && m_outst[c] < MAXO) begin
          e_rqa_rdy[c] = 1'b1;
          e_win = c;
          break;
        end
      end
    end
    cid       = int'(i_rss[8:7]);
    e_rss_vld = '0;
    if (i_rss_vld) e_rss_vld[cid] = 1'b1;
    e_rss_rd  = i_rss_vld && i_cl_rss_rd[cid] &&
                !(i_rss[2] && route_q.size() == (1 << RDP));
    have      = (route_q.size() > 0) || (e_rss_rd && i_rss[2]);
    owner     = (route_q.size() > 0) ? route_q[0] : cid;
    e_rsd_vld = '0;
    if (i_rsd_vld && have) e_rsd_vld[owner] = 1'b1;
    e_rsd_rd  = i_rsd_vld && have && i_cl_rsd_rd[owner];
    e_busy    = m_wr || (route_q.size() > 0);
    for (int k = 0; k < 4; k++) if (m_outst[k] != 0) e_busy = 1'b1;
  endtask

  task automatic model_step();
    model_eval();
    if (e_rqa_rdy != 4'b0000) begin
      m_rqa = i_cl_rqa[e_win*44 +: 44];
      m_wr  = 1'b1;
      m_rr  = (e_win + 1) % 4;
      m_outst[e_win]++;
    end else if (m_wr && i_rqa_rdy) begin
      m_wr = 1'b0;
    end
    if (e_rss_rd) begin
      m_outst[int'(i_rss[8:7])]--;
      if (i_rss[2]) route_q.push_back(int'(i_rss[8:7]));
    end
    if (e_rsd_rd) void'(route_q.pop_front());
  endtask

  // Model advances on the same edge as the DUT
  initial forever begin
    @(posedge clk);
    if (nrst) model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (nrst) begin
      model_eval();
      chk("m_rqa_rdy", o_cl_rqa_rdy, e_rqa_rdy);
      chk("m_rqa_wr", o_rqa_wr, m_wr);
      if (m_wr) chk("m_rqa", o_rqa, m_rqa);
      chk("m_rss_vld", o_cl_rss_vld, e_rss_vld);
      chk("m_rss", o_cl_rss, i_rss);
      chk("m_rss_rd", o_rss_rd, e_rss_rd);
      chk("m_rsd_vld", o_cl_rsd_vld, e_rsd_vld);
      if (e_rsd_vld != 4'b0000) chk("m_rsd", o_cl_rsd, i_rsd);
      chk("m_rsd_rd", o_rsd_rd, e_rsd_rd);
      chk("m_busy", o_busy, e_busy);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    i_cl_rqa_wr = '0;
    i_rqa_rdy   = 1'b1;
    i_rss_vld   = 1'b0;
    i_rss       = '0;
    i_rsd_vld   = 1'b0;
    i_rsd       = '0;
    i_cl_rss_rd = '0;
    i_cl_rsd_rd = '0;
  endtask

  task automatic do_reset();
    idle();
    nrst = 1'b0;
    model_reset();
    step(2);
    @(negedge clk);
    chk("rst_rqa", o_rqa, 44'h0);
    chk("rst_rqa_wr", o_rqa_wr, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_rdy", o_cl_rqa_rdy, 4'b0000);
    nrst = 1'b1;
    step();
  endtask

  initial begin
    i_cl_rqa = '0;
    idle();
    nrst = 1'b0;
    model_reset();

    // Single request from client 0 out of reset
    do_reset();
    i_cl_rqa[43:0] = 44'h0AB;
    i_cl_rqa_wr    = 4'b0001;
    @(negedge clk);
    chk("t1_grant", o_cl_rqa_rdy, 4'b0001);
    step();
    i_cl_rqa_wr = 4'b0000;
    @(negedge clk);
    chk("t1_rqa", o_rqa, 44'h0AB);
    chk("t1_wr", o_rqa_wr, 1'b1);
    chk("t1_busy", o_busy, 1'b1);
    step();
    i_cl_rqa_wr = 4'b0011;
    @(negedge clk);
    chk("t1_rr", o_cl_rqa_rdy, 4'b0010);
    idle();
    step();

    // All four clients requesting: strict rotation
    do_reset();
    for (int c = 0; c < 4; c++) i_cl_rqa[c*44 +: 44] = 44'h100 + 44'(c);
    i_cl_rqa_wr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_order", o_cl_rqa_rdy, exp_order[i]);
      step();
    end

    // Upstream stall: slice holds, no grants, resume on ready
    i_rqa_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_nogrant", o_cl_rqa_rdy, 4'b0000);
      chk("t3_hold", o_rqa, 44'h100);
      step();
    end
    i_rqa_rdy = 1'b1;
    @(negedge clk);
    chk("t3_resume", o_cl_rqa_rdy, 4'b0010);
    step();
    idle();

    // Outstanding limit on client 1, released by a status pop (mid-op reset first)
    do_reset();
    i_cl_rqa[44 +: 44] = 44'h0C1;
    i_cl_rqa_wr        = 4'b0010;
    @(negedge clk);
    chk("t4_g1", o_cl_rqa_rdy, 4'b0010);
    step();
    @(negedge clk);
    chk("t4_g2", o_cl_rqa_rdy, 4'b0010);
    step();
    @(negedge clk);
    chk("t4_block", o_cl_rqa_rdy, 4'b0000);
    step();
    i_rss       = 9'h080;
    i_rss_vld   = 1'b1;
    i_cl_rss_rd = 4'b0010;
    @(negedge clk);
    chk("t4_rss_vld", o_cl_rss_vld, 4'b0010);
    chk("t4_rss_rd", o_rss_rd, 1'b1);
    chk("t4_block2", o_cl_rqa_rdy, 4'b0000);
    step();
    i_rss_vld   = 1'b0;
    i_cl_rss_rd = 4'b0000;
    @(negedge clk);
    chk("t4_regrant", o_cl_rqa_rdy, 4'b0010);
    step();
    idle();

    // Bypass: read status and data for client 2 in the same cycle
    do_reset();
    i_cl_rqa[88 +: 44] = 44'h0C2;
    i_cl_rqa_wr        = 4'b0100;
    step();
    i_cl_rqa_wr = 4'b0000;
    step();
    i_rss       = 9'h105;
    i_rss_vld   = 1'b1;
    i_cl_rss_rd = 4'b0100;
    i_rsd       = 64'hDEAD_BEEF_0123_4567;
    i_rsd_vld   = 1'b1;
    i_cl_rsd_rd = 4'b0100;
    @(negedge clk);
    chk("t5_rss_vld", o_cl_rss_vld, 4'b0100);
    chk("t5_rsd_vld", o_cl_rsd_vld, 4'b0100);
    chk("t5_rss_rd", o_rss_rd, 1'b1);
    chk("t5_rsd_rd", o_rsd_rd, 1'b1);
    chk("t5_rsd", o_cl_rsd, 64'hDEAD_BEEF_0123_4567);
    chk("t5_err", o_cl_rss[1:0], 2'b01);
    step();
    idle();
    @(negedge clk);
    chk("t5_busy", o_busy, 1'b0);
    step();

    // Route FIFO full (depth 2): read status held, write status flows
    do_reset();
    for (int c = 0; c < 4; c++) begin
      i_cl_rqa[c*44 +: 44] = 44'h200 + 44'(c);
      i_cl_rqa_wr = 4'(1 << c);
      step();
    end
    i_cl_rqa_wr = 4'b0000;
    step();
    i_rss_vld   = 1'b1;
    i_rss       = 9'h004;
    i_cl_rss_rd = 4'b0001;
    step();
    i_rss       = 9'h084;
    i_cl_rss_rd = 4'b0010;
    step();
    i_rss       = 9'h104;
    i_cl_rss_rd = 4'b0100;
    @(negedge clk);
    chk("t6_hold", o_rss_rd, 1'b0);
    chk("t6_vld", o_cl_rss_vld, 4'b0100);
    step();
    @(negedge clk);
    chk("t6_hold2", o_rss_rd, 1'b0);
    step();
    i_rss       = 9'h180;
    i_cl_rss_rd = 4'b1000;
    @(negedge clk);
    chk("t6_wr_flow", o_rss_rd, 1'b1);
    step();
    i_rss       = 9'h104;
    i_cl_rss_rd = 4'b0100;
    i_rsd_vld   = 1'b1;
    i_rsd       = 64'h1111;
    i_cl_rsd_rd = 4'b0001;
    @(negedge clk);
    chk("t6_owner0", o_cl_rsd_vld, 4'b0001);
    chk("t6_rsd_rd", o_rsd_rd, 1'b1);
    chk("t6_still_hold", o_rss_rd, 1'b0);
    step();
    i_rsd_vld   = 1'b0;
    i_cl_rsd_rd = 4'b0000;
    @(negedge clk);
    chk("t6_release", o_rss_rd, 1'b1);
    step();
    i_rss_vld   = 1'b0;
    i_cl_rss_rd = 4'b0000;
    i_rsd_vld   = 1'b1;
    i_rsd       = 64'h2222;
    i_cl_rsd_rd = 4'b0010;
    @(negedge clk);
    chk("t6_owner1", o_cl_rsd_vld, 4'b0010);
    step();
    i_rsd       = 64'h3333;
    i_cl_rsd_rd = 4'b0100;
    @(negedge clk);
    chk("t6_owner2", o_cl_rsd_vld, 4'b0100);
    step();
    idle();
    @(negedge clk);
    chk("t6_idle", o_busy, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
